// File: rtl/sort_floats_seq_if.sv
// Handshake bundle for sort_floats_seq: upstream job channel and downstream result channel.
interface sort_floats_seq_if #(
  parameter int N    = 3,
  parameter int FLEN = 64
);
  logic                     up_valid;
  logic                     up_ready;
  logic [0:N-1][FLEN-1:0]   up_data;
  logic                     down_valid;
  logic                     down_ready;
  logic [0:N-1][FLEN-1:0]   down_data;
  logic                     down_err;

  // Producer/consumer side (drives jobs in, accepts results)
  modport master (
    output up_valid, up_data, down_ready,
    input  up_ready, down_valid, down_data, down_err
  );

  // Sorter side
  modport slave (
    input  up_valid, up_data, down_ready,
    output up_ready, down_valid, down_data, down_err
  );
endinterface

// File: rtl/sort_floats_seq.sv
// Multi-cycle ascending sorter: a fixed bubble-sort schedule of (N-1)^2 compare/swap
// steps over an internal buffer, sharing one floating-point <= comparator.

// IEEE-754 "a <= b" with NaN detection. err=1 when either operand is NaN (res forced 0).
// +0 and -0 compare equal so they are never reordered.
module f_less_or_equal #(
  parameter int FLEN = 64
) (
  input  logic [FLEN-1:0] a_i,
  input  logic [FLEN-1:0] b_i,
  output logic            res_o,
  output logic            err_o
);
  localparam int EW = (FLEN == 16) ? 5 : (FLEN == 32) ? 8 : 11;
  localparam int MW = FLEN - 1 - EW;

  logic            a_s, b_s, a_nan, b_nan;
  logic [FLEN-2:0] a_mag, b_mag;

  // Sign/magnitude ordering; negative values order by reversed magnitude
  always_comb begin
    a_s   = a_i[FLEN-1];
    b_s   = b_i[FLEN-1];
    a_mag = a_i[FLEN-2:0];
    b_mag = b_i[FLEN-2:0];
    a_nan = (&a_i[FLEN-2 -: EW]) && (|a_i[MW-1:0]);
    b_nan = (&b_i[FLEN-2 -: EW]) && (|b_i[MW-1:0]);
    err_o = a_nan | b_nan;
    res_o = 1'b0;
    if (err_o)                             res_o = 1'b0;
    else if (a_mag == '0 && b_mag == '0)   res_o = 1'b1;
    else if (a_s != b_s)                   res_o = a_s;
    else if (!a_s)                         res_o = (a_mag <= b_mag);
    else                                   res_o = (a_mag >= b_mag);
  end
endmodule

module sort_floats_seq #(
  parameter int N    = 3,
  parameter int FLEN = 64
) (
  input  logic                clk,
  input  logic                rst,
  sort_floats_seq_if.slave    sif
);
  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SORT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [IW-1:0]          pass_q, pass_d;
  logic [IW-1:0]          i_q, i_d;
  logic [IW-1:0]          i_nxt;
  logic [0:N-1][FLEN-1:0] elem_q, elem_d;
  logic                   err_q, err_d;

  logic [FLEN-1:0]        cmp_a, cmp_b;
  logic                   cmp_res, cmp_err;

  assign i_nxt = i_q + 1'b1;
  assign cmp_a = elem_q[i_q];
  assign cmp_b = elem_q[i_nxt];

  f_less_or_equal #(.FLEN(FLEN)) u_cmp (
    .a_i   (cmp_a),
    .b_i   (cmp_b),
    .res_o (cmp_res),
    .err_o (cmp_err)
  );

  // Next-state: job load, one compare/swap per SORT cycle, result hold in DONE
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    i_d     = i_q;
    elem_d  = elem_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (sif.up_valid) begin
          elem_d  = sif.up_data;
          pass_d  = '0;
          i_d     = '0;
          err_d   = 1'b0;
          state_d = S_SORT;
        end
      end
      S_SORT: begin
        if (cmp_err) begin
          err_d = 1'b1;
        end else if (!cmp_res) begin
          elem_d[i_q]   = cmp_b;
          elem_d[i_nxt] = cmp_a;
        end
        if (i_q == LAST) begin
          i_d    = '0;
          pass_d = pass_q + 1'b1;
          if (pass_q == LAST) state_d = S_DONE;
        end else begin
          i_d = i_nxt;
        end
      end
      S_DONE: begin
        if (sif.down_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset clears the buffer so the result bus reads zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pass_q  <= '0;
      i_q     <= '0;
      elem_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      i_q     <= i_d;
      elem_q  <= elem_d;
      err_q   <= err_d;
    end
  end

  assign sif.up_ready   = (state_q == S_IDLE);
  assign sif.down_valid = (state_q == S_DONE);
  assign sif.down_data  = elem_q;
  assign sif.down_err   = err_q;
endmodule
